dm9000_bus_ctrl: RTL and testbench
==================================

DM9000_BUS_CTRL -- requirements
Module: dm9000_bus_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16; host data width, 8 or 16.
REQ-002 SHALL have parameter SETUP_CYC, default 1; cycles from cmd/cs/data valid to strobe assert, range 1..15.
REQ-003 SHALL have parameter PULSE_CYC, default 2; cycles ior/iow held low, range 1..15.
REQ-004 SHALL have parameter HOLD_CYC, default 1; cycles after strobe release with cmd/cs/data held, range 1..15.
REQ-005 SHALL have parameter RECOV_CYC, default 2; idle cycles between consecutive bus accesses, range 0..15.
REQ-006 SHALL have ports: clk  in  1  sole clock; one clock, reset is synchronous and active-high; rst  in  1  synchronous active-high reset.
REQ-007 SHALL have ports: req  in  1  start access; raw  in  1  skip index phase; wr  in  1  1=write 0=read; reg_addr  in  8  DM9000 register index; wdata  in  DATA_W  write data.
REQ-008 SHALL have ports: busy  out  1  access in progress; done  out  1  one-cycle completion pulse; rdata  out  DATA_W  read data.
REQ-009 SHALL have ports: eth_data  inout  16  chip data bus; eth_cs  out  1  chip select, active low; eth_cmd  out  1  0=index 1=data; eth_ior  out  1  read strobe, active low; eth_iow  out  1  write strobe, active low; eth_int  in  1  chip interrupt; irq  out  1  interrupt to host.

Function
REQ-010 SHALL implement states IDLE, IDX_SETUP, IDX_PULSE, IDX_HOLD, DAT_SETUP, DAT_PULSE, DAT_HOLD, RECOV.
REQ-011 SHALL, in IDLE with req=1, capture raw/wr/reg_addr/wdata and go to IDX_SETUP (raw=0) or DAT_SETUP (raw=1); busy=1 from the next cycle.
REQ-012 SHALL ignore req while busy=1; captured fields SHALL not change mid-access.
REQ-013 SHALL stay SETUP_CYC, PULSE_CYC, HOLD_CYC cycles in each SETUP, PULSE, HOLD state respectively, then advance IDX_HOLD->DAT_SETUP, DAT_HOLD->RECOV.
REQ-014 SHALL drive eth_cs=0 in all IDX_*/DAT_* states, 1 in IDLE and RECOV.
REQ-015 SHALL drive eth_cmd=0 in IDX_* states, 1 otherwise.
REQ-016 SHALL drive eth_iow=0 in IDX_PULSE always and in DAT_PULSE when wr=1; eth_ior=0 in DAT_PULSE when wr=0; both 1 elsewhere; never both 0.
REQ-017 SHALL drive eth_data={8'h00,reg_addr} in IDX_*; captured wdata (zero-extended if DATA_W=8) in DAT_* when wr=1; high-Z otherwise.
REQ-018 SHALL register eth_data[DATA_W-1:0] into rdata on the last DAT_PULSE cycle of a read; rdata SHALL hold until the next read.
REQ-019 SHALL pulse done=1 for one cycle on the DAT_HOLD->RECOV transition; busy SHALL fall on entry to IDLE.
REQ-020 SHALL stay RECOV_CYC cycles in RECOV (RECOV_CYC=0: DAT_HOLD goes directly to IDLE) before accepting a new req.
REQ-021 SHALL give total access latency req-to-done = 1+(raw?0:S+P+H)+S+P+H cycles (S,P,H = SETUP/PULSE/HOLD_CYC).

Reset
REQ-022 SHALL on rst=1 force IDLE on the next clk edge, abandoning any access mid-cycle, and set eth_cs=1, eth_ior=1, eth_iow=1, eth_cmd=1, eth_data high-Z, busy=0, done=0, rdata=0, irq=0.
REQ-023 SHALL ignore req in the cycle rst=1.

Configuration
REQ-024 SHALL, with DM9000_INT_SYNC_EN defined, pass eth_int through a two-flop synchronizer to irq (2-cycle latency, both flops reset to 0).
REQ-025 SHALL, without DM9000_INT_SYNC_EN, tie irq=0 and leave eth_int unused.

Verification
REQ-026 Defaults, req raw=0 wr=1 reg_addr=8'h1F wdata=16'h0001 -> eth_data=16'h001F with cmd=0 iow low 2 cycles, then 16'h0001 with cmd=1 iow low 2 cycles, done at cycle 9.
REQ-027 Defaults, req raw=0 wr=0 reg_addr=8'h28, chip model drives 16'h0A46 -> rdata=16'h0A46, ior low 2 cycles, iow low only in index phase, done at cycle 9.
REQ-028 DATA_W=8, raw=1 wr=0, model drives 16'hBE5A -> rdata=8'h5A, no index phase, done at cycle 5.
REQ-029 Back-to-back req held high, RECOV_CYC=2 -> second eth_cs fall exactly 3 cycles after first done; req during busy causes no extra access.
REQ-030 rst asserted in DAT_PULSE of a write -> next cycle all strobes 1, eth_data high-Z, busy=0, no done pulse.
REQ-031 DM9000_INT_SYNC_EN defined, eth_int 0->1 -> irq=1 two cycles later; undefined -> irq stays 0.

Source files
------------

// File: rtl/dm9000_bus_ctrl.sv
// dm9000_bus_ctrl: DM9000 host bus sequencer (index cycle + data cycle).
// Define DM9000_INT_SYNC_EN to add a two-flop eth_int -> irq synchronizer.
module dm9000_bus_ctrl #(
    parameter int DATA_W    = 16,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1,
    parameter int RECOV_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              raw,
    input  logic              wr,
    input  logic [7:0]        reg_addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    inout  wire  [15:0]       eth_data,
    output logic              eth_cs,
    output logic              eth_cmd,
    output logic              eth_ior,
    output logic              eth_iow,
    input  logic              eth_int,
    output logic              irq
);

    typedef enum logic [2:0] {
        IDLE, IDX_SETUP, IDX_PULSE, IDX_HOLD,
        DAT_SETUP, DAT_PULSE, DAT_HOLD, RECOV
    } state_t;

    // Last count value in each timed state; R_LAST is unused when RECOV_CYC=0.
    localparam logic [3:0] S_LAST = 4'(SETUP_CYC - 1);
    localparam logic [3:0] P_LAST = 4'(PULSE_CYC - 1);
    localparam logic [3:0] H_LAST = 4'(HOLD_CYC - 1);
    localparam logic [3:0] R_LAST = 4'(RECOV_CYC - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [7:0]        addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              done_q, done_d;

    logic              cs_c, cmd_c, ior_c, iow_c, drv_c;
    logic [15:0]       dout_c;
    logic [15:0]       wdata_ext;

    assign wdata_ext = 16'(wdata_q);

    // Next-state, capture and bus-pin decode.
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        cs_c    = 1'b1;
        cmd_c   = 1'b1;
        ior_c   = 1'b1;
        iow_c   = 1'b1;
        drv_c   = 1'b0;
        dout_c  = 16'h0000;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    wr_d    = wr;
                    addr_d  = reg_addr;
                    wdata_d = wdata;
                    state_d = raw ? DAT_SETUP : IDX_SETUP;
                end
            end
            IDX_SETUP: begin
                cs_c   = 1'b0;
                cmd_c  = 1'b0;
                drv_c  = 1'b1;
                dout_c = {8'h00, addr_q};
                if (cnt_q == S_LAST) state_d = IDX_PULSE;
            end
            IDX_PULSE: begin
                cs_c   = 1'b0;
                cmd_c  = 1'b0;
                iow_c  = 1'b0;
                drv_c  = 1'b1;
                dout_c = {8'h00, addr_q};
                if (cnt_q == P_LAST) state_d = IDX_HOLD;
            end
            IDX_HOLD: begin
                cs_c   = 1'b0;
                cmd_c  = 1'b0;
                drv_c  = 1'b1;
                dout_c = {8'h00, addr_q};
                if (cnt_q == H_LAST) state_d = DAT_SETUP;
            end
            DAT_SETUP: begin
                cs_c   = 1'b0;
                drv_c  = wr_q;
                dout_c = wdata_ext;
                if (cnt_q == S_LAST) state_d = DAT_PULSE;
            end
            DAT_PULSE: begin
                cs_c   = 1'b0;
                drv_c  = wr_q;
                dout_c = wdata_ext;
                iow_c  = ~wr_q;
                ior_c  = wr_q;
                if (cnt_q == P_LAST) begin
                    if (!wr_q) rdata_d = eth_data[DATA_W-1:0];
                    state_d = DAT_HOLD;
                end
            end
            DAT_HOLD: begin
                cs_c   = 1'b0;
                drv_c  = wr_q;
                dout_c = wdata_ext;
                if (cnt_q == H_LAST) begin
                    done_d  = 1'b1;
                    state_d = (RECOV_CYC == 0) ? IDLE : RECOV;
                end
            end
            RECOV: begin
                if (cnt_q == R_LAST) state_d = IDLE;
            end
        endcase
        cnt_d = (state_d != state_q) ? 4'd0 : cnt_q + 4'd1;
    end

    // State, phase counter and captured-request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign rdata    = rdata_q;
    assign eth_cs   = cs_c;
    assign eth_cmd  = cmd_c;
    assign eth_ior  = ior_c;
    assign eth_iow  = iow_c;
    assign eth_data = drv_c ? dout_c : 16'hzzzz;

`ifdef DM9000_INT_SYNC_EN
    logic [1:0] int_sync_q;

    // Two-flop synchronizer for the asynchronous chip interrupt.
    always_ff @(posedge clk) begin
        if (rst) int_sync_q <= 2'b00;
        else     int_sync_q <= {int_sync_q[0], eth_int};
    end

    assign irq = int_sync_q[1];
`else
    logic unused_eth_int;
    assign unused_eth_int = eth_int;
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_dm9000_bus_ctrl.sv
// tb_dm9000_bus_ctrl: directed checks of the DM9000 bus sequencer.
// Default instance (16-bit) plus an 8-bit instance for the raw read case.
module tb_dm9000_bus_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req, raw, wr, eth_int;
    logic [7:0]  reg_addr;
    logic [15:0] wdata;
    logic        busy, done;
    logic [15:0] rdata;
    wire  [15:0] eth_data;
    logic        eth_cs, eth_cmd, eth_ior, eth_iow, irq;

    logic        model_en, force_en;
    logic [15:0] model_val;

    logic        req8, raw8, wr8;
    logic [7:0]  wdata8;
    logic        busy8, done8;
    logic [7:0]  rdata8;
    wire  [15:0] eth_data8;
    logic        cs8, cmd8, ior8, iow8, irq8;
    logic [15:0] model8_val;

    int total = 0;
    int bad   = 0;

`ifdef DM9000_INT_SYNC_EN
    localparam logic IRQ_EXP = 1'b1;
`else
    localparam logic IRQ_EXP = 1'b0;
`endif

    assign eth_data  = force_en ? 16'h0000 :
                       (model_en && !eth_ior) ? model_val : 16'hzzzz;
    assign eth_data8 = !ior8 ? model8_val : 16'hzzzz;

    dm9000_bus_ctrl u_dut (
        .clk(clk), .rst(rst), .req(req), .raw(raw), .wr(wr),
        .reg_addr(reg_addr), .wdata(wdata), .busy(busy), .done(done),
        .rdata(rdata), .eth_data(eth_data), .eth_cs(eth_cs),
        .eth_cmd(eth_cmd), .eth_ior(eth_ior), .eth_iow(eth_iow),
        .eth_int(eth_int), .irq(irq)
    );

    dm9000_bus_ctrl #(.DATA_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .req(req8), .raw(raw8), .wr(wr8),
        .reg_addr(8'h00), .wdata(wdata8), .busy(busy8), .done(done8),
        .rdata(rdata8), .eth_data(eth_data8), .eth_cs(cs8),
        .eth_cmd(cmd8), .eth_ior(ior8), .eth_iow(iow8),
        .eth_int(eth_int), .irq(irq8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b1; req8 = 1'b1;
        tick(); tick();
        total++; if (eth_cs !== 1'b1) begin bad++; $display("FAIL rst_cs got=%b exp=1", eth_cs); end
        total++; if (eth_ior !== 1'b1) begin bad++; $display("FAIL rst_ior got=%b exp=1", eth_ior); end
        total++; if (eth_iow !== 1'b1) begin bad++; $display("FAIL rst_iow got=%b exp=1", eth_iow); end
        total++; if (eth_cmd !== 1'b1) begin bad++; $display("FAIL rst_cmd got=%b exp=1", eth_cmd); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
        total++; if (rdata !== 16'h0000) begin bad++; $display("FAIL rst_rdata got=%h exp=0000", rdata); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b exp=0", irq); end
        total++; if (rdata8 !== 8'h00) begin bad++; $display("FAIL rst_rdata8 got=%h exp=00", rdata8); end
        rst = 1'b0; req = 1'b0; req8 = 1'b0;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_req_ignored busy got=%b exp=0", busy); end
        total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL rst_req_ignored busy8 got=%b exp=0", busy8); end
        repeat (3) tick();
    endtask

    task automatic test_write();
        int done_at = 0, n_done = 0, idx_iow = 0, dat_iow = 0, n_ior = 0, dmis = 0;
        reg_addr = 8'h1F; wdata = 16'h0001; wr = 1'b0 | 1'b1; raw = 1'b0;
        req = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (i == 1) begin
                req = 1'b0;
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL wr_busy got=%b exp=1", busy); end
                total++; if (eth_data !== 16'h001F) begin bad++; $display("FAIL wr_idx_setup_data got=%h exp=001f", eth_data); end
            end
            if (!eth_iow && !eth_cmd) begin idx_iow++; if (eth_data !== 16'h001F) dmis++; end
            if (!eth_iow && eth_cmd) begin dat_iow++; if (eth_data !== 16'h0001) dmis++; end
            if (!eth_iow && eth_cs) dmis++;
            if (!eth_ior) n_ior++;
            if (done) begin n_done++; if (done_at == 0) done_at = i; end
        end
        total++; if (idx_iow != 2) begin bad++; $display("FAIL wr_idx_iow got=%0d exp=2", idx_iow); end
        total++; if (dat_iow != 2) begin bad++; $display("FAIL wr_dat_iow got=%0d exp=2", dat_iow); end
        total++; if (n_ior != 0) begin bad++; $display("FAIL wr_ior got=%0d exp=0", n_ior); end
        total++; if (dmis != 0) begin bad++; $display("FAIL wr_bus_data bad_cycles got=%0d exp=0", dmis); end
        total++; if (done_at != 9) begin bad++; $display("FAIL wr_done_cycle got=%0d exp=9", done_at); end
        total++; if (n_done != 1) begin bad++; $display("FAIL wr_done_count got=%0d exp=1", n_done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_read();
        int done_at = 0, idx_iow = 0, dat_iow = 0, n_ior = 0, dmis = 0;
        reg_addr = 8'h28; wr = 1'b0; raw = 1'b0;
        model_en = 1'b1; model_val = 16'h0A46;
        req = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (i == 1) req = 1'b0;
            if (!eth_iow && !eth_cmd) begin idx_iow++; if (eth_data !== 16'h0028) dmis++; end
            if (!eth_iow && eth_cmd) dat_iow++;
            if (!eth_ior) begin n_ior++; if (eth_cmd !== 1'b1 || eth_cs !== 1'b0) dmis++; end
            if (done && done_at == 0) done_at = i;
        end
        model_en = 1'b0;
        total++; if (rdata !== 16'h0A46) begin bad++; $display("FAIL rd_rdata got=%h exp=0a46", rdata); end
        total++; if (n_ior != 2) begin bad++; $display("FAIL rd_ior got=%0d exp=2", n_ior); end
        total++; if (idx_iow != 2) begin bad++; $display("FAIL rd_idx_iow got=%0d exp=2", idx_iow); end
        total++; if (dat_iow != 0) begin bad++; $display("FAIL rd_dat_iow got=%0d exp=0", dat_iow); end
        total++; if (dmis != 0) begin bad++; $display("FAIL rd_bus bad_cycles got=%0d exp=0", dmis); end
        total++; if (done_at != 9) begin bad++; $display("FAIL rd_done_cycle got=%0d exp=9", done_at); end
    endtask

    task automatic test_raw8();
        int done_at = 0, n_cmd0 = 0, n_ior = 0;
        raw8 = 1'b1; wr8 = 1'b0; model8_val = 16'hBE5A;
        req8 = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 1) req8 = 1'b0;
            if (!cmd8) n_cmd0++;
            if (!ior8) n_ior++;
            if (done8 && done_at == 0) done_at = i;
        end
        total++; if (rdata8 !== 8'h5A) begin bad++; $display("FAIL raw8_rdata got=%h exp=5a", rdata8); end
        total++; if (n_cmd0 != 0) begin bad++; $display("FAIL raw8_index_cycles got=%0d exp=0", n_cmd0); end
        total++; if (n_ior != 2) begin bad++; $display("FAIL raw8_ior got=%0d exp=2", n_ior); end
        total++; if (done_at != 5) begin bad++; $display("FAIL raw8_done_cycle got=%0d exp=5", done_at); end
    endtask

    task automatic test_back_to_back();
        int falls = 0, fall1 = 0, fall2 = 0, done1 = 0, n_done = 0, dmis = 0;
        logic prev_cs;
        reg_addr = 8'h05; wdata = 16'h1234; wr = 1'b1; raw = 1'b0;
        prev_cs = eth_cs;
        req = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 3) wdata = 16'hDEAD;
            if (prev_cs && !eth_cs) begin
                falls++;
                if (falls == 1) fall1 = i;
                if (falls == 2) begin fall2 = i; req = 1'b0; end
            end
            prev_cs = eth_cs;
            if (!eth_iow && eth_cmd) begin
                if (falls == 1 && eth_data !== 16'h1234) dmis++;
                if (falls == 2 && eth_data !== 16'hDEAD) dmis++;
            end
            if (done) begin n_done++; if (done1 == 0) done1 = i; end
        end
        req = 1'b0;
        total++; if (fall1 != 1) begin bad++; $display("FAIL b2b_first_cs got=%0d exp=1", fall1); end
        total++; if (fall2 - done1 != 3) begin bad++; $display("FAIL b2b_gap got=%0d exp=3", fall2 - done1); end
        total++; if (falls != 2) begin bad++; $display("FAIL b2b_accesses got=%0d exp=2", falls); end
        total++; if (n_done != 2) begin bad++; $display("FAIL b2b_done_count got=%0d exp=2", n_done); end
        total++; if (dmis != 0) begin bad++; $display("FAIL b2b_captured_data bad_cycles got=%0d exp=0", dmis); end
    endtask

    task automatic test_reset_mid();
        int n_done = 0;
        reg_addr = 8'h11; wdata = 16'hFFFF; wr = 1'b1; raw = 1'b0;
        req = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 1) req = 1'b0;
        end
        total++; if (eth_iow !== 1'b0 || eth_cmd !== 1'b1) begin bad++; $display("FAIL rmid_in_dat_pulse iow=%b cmd=%b exp iow=0 cmd=1", eth_iow, eth_cmd); end
        rst = 1'b1;
        tick();
        force_en = 1'b1;
        #1;
        total++; if (eth_data !== 16'h0000) begin bad++; $display("FAIL rmid_bus_released got=%h exp=0000", eth_data); end
        total++; if (eth_iow !== 1'b1 || eth_ior !== 1'b1) begin bad++; $display("FAIL rmid_strobes iow=%b ior=%b exp=1,1", eth_iow, eth_ior); end
        total++; if (eth_cs !== 1'b1 || eth_cmd !== 1'b1) begin bad++; $display("FAIL rmid_cs_cmd cs=%b cmd=%b exp=1,1", eth_cs, eth_cmd); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        force_en = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done) n_done++;
            tick();
        end
        total++; if (n_done != 0) begin bad++; $display("FAIL rmid_no_done got=%0d exp=0", n_done); end
    endtask

    task automatic test_irq();
        eth_int = 1'b0;
        tick(); tick();
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_idle got=%b exp=0", irq); end
        eth_int = 1'b1;
        tick();
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_one_cycle got=%b exp=0", irq); end
        tick();
        total++; if (irq !== IRQ_EXP) begin bad++; $display("FAIL irq_two_cycles got=%b exp=%b", irq, IRQ_EXP); end
        total++; if (irq8 !== IRQ_EXP) begin bad++; $display("FAIL irq8_two_cycles got=%b exp=%b", irq8, IRQ_EXP); end
        eth_int = 1'b0;
        tick(); tick();
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; raw = 1'b0; wr = 1'b0; eth_int = 1'b0;
        reg_addr = 8'h00; wdata = 16'h0000;
        model_en = 1'b0; force_en = 1'b0; model_val = 16'h0000;
        req8 = 1'b0; raw8 = 1'b1; wr8 = 1'b0; wdata8 = 8'h00;
        model8_val = 16'h0000;
        test_reset();
        test_write();
        test_read();
        test_raw8();
        test_back_to_back();
        test_reset_mid();
        test_irq();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
